// File: rtl/cpu_pkg.sv
// Shared encodings for the store path: access sizes, store FSM states and RAM depth.
// The request checker lives here so the top module stays a pure FSM plus datapath.
package cpu_pkg;

    localparam int DEFAULT_DEPTH = 64;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } store_state_e;

    // True when a request must be rejected: reserved size, misalignment, or word index past the RAM.
    function automatic logic req_is_bad(input logic [31:0] addr, input logic [1:0] size,
                                        input int depth);
        logic [31:0] idx;
        logic        bad;
        idx = {2'b00, addr[31:2]};
        bad = 1'b0;
        case (size)
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr[1:0] != 2'b00);
            SIZE_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        if (idx >= 32'(depth)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Execute-stage request handshake plus the word RAM port seen by the store unit.
// slave is the store unit's view; master is the requester/RAM side.
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        error;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    modport slave (
        input  req_valid, req_address, req_data, req_size, mem_dataout,
        output req_ready, done, error, mem_write, mem_address, mem_datain
    );

    modport master (
        output req_valid, req_address, req_data, req_size, mem_dataout,
        input  req_ready, done, error, mem_write, mem_address, mem_datain
    );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane insert: replaces the addressed byte/halfword of the old word.
// Bits of the new data above the access size are ignored.
module store_lane_merge
    import cpu_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        case (i_size)
            SIZE_BYTE: begin
                case (i_lane)
                    2'd0:    o_merged[7:0]   = i_new[7:0];
                    2'd1:    o_merged[15:8]  = i_new[7:0];
                    2'd2:    o_merged[23:16] = i_new[7:0];
                    default: o_merged[31:24] = i_new[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (i_lane[1]) o_merged[31:16] = i_new[15:0];
                else           o_merged[15:0]  = i_new[15:0];
            end
            SIZE_WORD: o_merged = i_new;
            default:   o_merged = i_old;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time and commits it to the word RAM,
// using read-modify-write for byte/halfword stores.
module store_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    store_unit_if.slave  bus
);

    store_state_e r_state;
    store_state_e w_next;
    logic [31:0]  r_addr;
    logic [31:0]  r_data;
    size_e        r_size;

    logic         w_ready;
    logic         w_accept;
    logic         w_bad;
    logic [31:0]  w_merged;
    logic         w_mem_write;
    logic [31:0]  w_mem_address;
    logic [31:0]  w_mem_datain;
    logic         w_done;
    logic         w_error;

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign w_ready  = (r_state == IDLE) && !i_rst;
    assign w_accept = bus.req_valid && w_ready;
    assign w_bad    = req_is_bad(bus.req_address, bus.req_size, DEPTH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= SIZE_BYTE;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= bus.req_address;
                r_data <= bus.req_data;
                r_size <= size_e'(bus.req_size);
            end
        end
    end

    store_lane_merge u_merge (
        .i_old    (bus.mem_dataout),
        .i_new    (r_data),
        .i_size   (r_size),
        .i_lane   (r_addr[1:0]),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next        = r_state;
        w_mem_write   = 1'b0;
        w_mem_address = '0;
        w_mem_datain  = '0;
        w_done        = 1'b0;
        w_error       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad)                                    w_next = ERR;
                    else if (size_e'(bus.req_size) == SIZE_WORD)  w_next = WRITE;
                    else                                          w_next = READ;
                end
            end
            READ: begin
                w_mem_address = {2'b00, r_addr[31:2]};
                w_next        = MERGE;
            end
            MERGE: begin
                w_mem_address = {2'b00, r_addr[31:2]};
                w_mem_write   = 1'b1;
                w_mem_datain  = w_merged;
                w_done        = 1'b1;
                w_next        = IDLE;
            end
            WRITE: begin
                w_mem_address = {2'b00, r_addr[31:2]};
                w_mem_write   = 1'b1;
                w_mem_datain  = r_data;
                w_done        = 1'b1;
                w_next        = IDLE;
            end
            ERR: begin
                w_error = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.req_ready   = w_ready;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_address = w_mem_address;
    assign bus.mem_datain  = w_mem_datain;
    assign bus.done        = w_done;
    assign bus.error       = w_error;

endmodule
